subleq_console_tx: RTL and testbench

//   Memory-mapped console output device for the subleq CPU.

---
 rtl/subleq_console_tx.sv | 179 +++++++++++++++++
 tb/tb_subleq_console_tx.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/subleq_console_tx.sv
// -----------------------------------------------------------------------------
// subleq_console_tx
//   Memory-mapped console output for the subleq CPU. Claims two bus words:
//     BASE   : TX data. Reads 0; a store pushes (0 - wdata)[7:0] into the FIFO,
//              so "subleq a, BASE" queues the character mem[a].
//     BASE+1 : status {.., overflow, tx_busy, empty, full}; any store clears
//              the sticky overflow flag.
//   Queued bytes are shifted out as UART 8N1 frames, CLKS_PER_BIT clocks/bit.
//
// Ports
//   clk        system clock, rising edge
//   areset     synchronous active-high reset
//   bus_addr   CPU memory address
//   bus_wdata  CPU store data
//   bus_we     CPU store strobe (one cycle per store)
//   bus_sel    high when bus_addr hits BASE or BASE+1 (combinational)
//   bus_rdata  register read data (combinational)
//   tx         serial output, idle high (registered)
//   tx_busy    high while a frame is being shifted (registered)
// -----------------------------------------------------------------------------
module subleq_console_tx #(
    parameter int                   WORD_SIZE    = 16,
    parameter logic [WORD_SIZE-1:0] BASE         = 16'hff00,
    parameter int                   DEPTH        = 4,
    parameter int                   CLKS_PER_BIT = 4
) (
    input  logic                 clk,
    input  logic                 areset,
    input  logic [WORD_SIZE-1:0] bus_addr,
    input  logic [WORD_SIZE-1:0] bus_wdata,
    input  logic                 bus_we,
    output logic                 bus_sel,
    output logic [WORD_SIZE-1:0] bus_rdata,
    output logic                 tx,
    output logic                 tx_busy
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FCNT_W = $clog2(DEPTH) + 1;
    localparam int BCNT_W = $clog2(CLKS_PER_BIT + 1);

    localparam logic [WORD_SIZE-1:0] STAT_ADDR  = BASE + WORD_SIZE'(1);
    localparam logic [BCNT_W-1:0]    BIT_RELOAD = BCNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    // ---------------------------------------------------------------- bus side
    logic              hit_data, hit_stat;
    logic              push, drop, pop;
    logic              full, empty, overflow;
    logic [7:0]        push_byte;
    logic              unused_wdata_hi;

    logic [7:0]        mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [FCNT_W-1:0] count;

    state_t            state;
    logic [7:0]        shreg;
    logic [2:0]        bit_idx;
    logic [BCNT_W-1:0] bit_cnt;

    assign hit_data = (bus_addr == BASE);
    assign hit_stat = (bus_addr == STAT_ADDR);
    assign bus_sel  = hit_data | hit_stat;

    assign full  = (count == FCNT_W'(DEPTH));
    assign empty = (count == '0);

    // full is the pre-edge value, so a store into a full FIFO is dropped even
    // when the shifter pops at the same edge.
    assign push = bus_we && hit_data && !full;
    assign drop = bus_we && hit_data && full;
    assign pop  = (state == IDLE) && !empty;

    // The low byte of a negation depends only on the low byte of the operand.
    assign push_byte       = 8'd0 - bus_wdata[7:0];
    assign unused_wdata_hi = ^bus_wdata[WORD_SIZE-1:8];

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the if/else can leave it holding a value (a latch).
    always_comb begin
        bus_rdata = '0;
        if (hit_stat) begin
            bus_rdata = WORD_SIZE'({overflow, tx_busy, empty, full});
        end
    end

    // ---------------------------------------------------------------- FIFO
    // NOTE: state registers use non-blocking (<=) assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (areset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end else if (bus_we && hit_stat) begin
                overflow <= 1'b0;
            end
        end
    end

    // NOTE: the storage array has no reset; validity is tracked by the
    // pointers and count, and leaving it unreset lets it map to plain RAM.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_byte;
    end

    // ---------------------------------------------------------------- shifter
    always_ff @(posedge clk) begin
        if (areset) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            shreg   <= '0;
            bit_idx <= '0;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        shreg   <= mem[rd_ptr];
                        state   <= START;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        bit_cnt <= BIT_RELOAD;
                    end
                end
                START: begin
                    if (bit_cnt == '0) begin
                        state   <= DATA;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        bit_cnt <= BIT_RELOAD;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (bit_cnt == '0) begin
                        bit_cnt <= BIT_RELOAD;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                STOP: begin
                    // The IDLE cycle after STOP is where the next pop happens,
                    // giving a 10*CLKS_PER_BIT+1 streaming frame period.
                    if (bit_cnt == '0) begin
                        state   <= IDLE;
                        tx_busy <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_subleq_console_tx.sv
// -----------------------------------------------------------------------------
// tb_subleq_console_tx
//   Self-checking bench for subleq_console_tx (WORD_SIZE=16, defaults).
//   A behavioural model (byte queue + frame timeline) predicts tx, tx_busy,
//   bus_sel and bus_rdata after every clock; table vectors and hand sequences
//   cover the register map and the multi-cycle corner cases.
// -----------------------------------------------------------------------------
module tb_subleq_console_tx;

    localparam int          C    = 4;
    localparam int          D    = 4;
    localparam logic [15:0] BASE = 16'hff00;
    localparam logic [15:0] STAT = 16'hff01;

    logic        clk = 1'b0;
    logic        areset;
    logic [15:0] bus_addr, bus_wdata, bus_rdata;
    logic        bus_we, bus_sel, tx, tx_busy;

    always #5 clk = ~clk;

    subleq_console_tx dut (
        .clk       (clk),
        .areset    (areset),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_we    (bus_we),
        .bus_sel   (bus_sel),
        .bus_rdata (bus_rdata),
        .tx        (tx),
        .tx_busy   (tx_busy)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    // ------------------------------------------------------------ model
    // Queue of pending bytes; ft = clocks since the pop edge of the frame in
    // flight (-1 when idle). A frame lasts 10 bit times of C clocks each.
    logic [7:0] mq[$];
    int         ft = -1;
    logic [7:0] fbyte;
    logic       m_ov = 1'b0;

    function automatic logic m_tx();
        int pos;
        if (ft < 0) return 1'b1;
        pos = ft / C;
        if (pos == 0) return 1'b0;
        if (pos <= 8) return fbyte[pos-1];
        return 1'b1;
    endfunction

    function automatic logic [15:0] m_rdata(input logic [15:0] a);
        if (a == STAT)
            return {12'b0, m_ov, (ft >= 0), (mq.size() == 0), (mq.size() == D)};
        return 16'h0000;
    endfunction

    task automatic model_edge();
        bit pre_full;
        if (areset) begin
            mq.delete();
            ft   = -1;
            m_ov = 1'b0;
            return;
        end
        pre_full = (mq.size() == D);
        if (ft >= 0) begin
            ft++;
            if (ft == 10 * C) ft = -1;
        end else if (mq.size() > 0) begin
            fbyte = mq.pop_front();
            ft    = 0;
        end
        if (bus_we && bus_addr == BASE) begin
            if (pre_full) m_ov = 1'b1;
            else          mq.push_back(8'(16'd0 - bus_wdata));
        end
        if (bus_we && bus_addr == STAT) m_ov = 1'b0;
    endtask

    // ------------------------------------------------------------ helpers
    task automatic drive(input logic [15:0] a, input logic [15:0] d, input logic we);
        bus_addr  = a;
        bus_wdata = d;
        bus_we    = we;
    endtask

    // One clock: advance the model with pre-edge inputs, then compare #1 later.
    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
        check("tx",        {15'b0, tx},      {15'b0, m_tx()});
        check("tx_busy",   {15'b0, tx_busy}, {15'b0, (ft >= 0)});
        check("bus_sel",   {15'b0, bus_sel}, {15'b0, (bus_addr == BASE || bus_addr == STAT)});
        check("bus_rdata", bus_rdata,        m_rdata(bus_addr));
    endtask

    task automatic wait_busy(input logic val, input int budget);
        for (int i = 0; i < budget && tx_busy !== val; i++) tick();
        check("wait_busy", {15'b0, tx_busy}, {15'b0, val});
    endtask

    typedef struct {
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        we;
        logic        exp_sel;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs[9];

    logic [9:0] frame_41;
    int         busy_cycles;
    int         r;

    initial begin
        // Register-map vectors, applied from an idle, empty, reset block.
        vecs[0] = '{16'hff00, 16'h0000, 1'b0, 1'b1, 16'h0000};
        vecs[1] = '{16'hff01, 16'h0000, 1'b0, 1'b1, 16'h0002};
        vecs[2] = '{16'hff02, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[3] = '{16'h0000, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[4] = '{16'hfeff, 16'h0000, 1'b0, 1'b0, 16'h0000};
        vecs[5] = '{16'hff02, 16'hffbf, 1'b1, 1'b0, 16'h0000};
        vecs[6] = '{16'hff01, 16'h0000, 1'b0, 1'b1, 16'h0002};
        vecs[7] = '{16'hff01, 16'h1234, 1'b1, 1'b1, 16'h0002};
        vecs[8] = '{16'hffff, 16'h0000, 1'b0, 1'b0, 16'h0000};

        // stop, data 0x41 MSB..LSB, start
        frame_41 = 10'b1_01000001_0;

        areset = 1'b1;
        drive(16'h0000, 16'h0000, 1'b0);
        tick();
        tick();
        areset = 1'b0;

        // 1. idle after reset
        drive(STAT, 16'h0000, 1'b0);
        for (int i = 0; i < 20; i++) tick();
        check("idle_status", bus_rdata, 16'h0002);
        check("idle_tx", {15'b0, tx}, 16'h0001);

        // Register map table
        for (int i = 0; i < 9; i++) begin
            drive(vecs[i].addr, vecs[i].wdata, vecs[i].we);
            #1;
            check($sformatf("vec%0d_sel", i), {15'b0, bus_sel}, {15'b0, vecs[i].exp_sel});
            check($sformatf("vec%0d_rdata", i), bus_rdata, vecs[i].exp_rdata);
            tick();
        end

        // 2. single store of 0xffbf -> byte 0x41, latency and waveform
        drive(BASE, 16'hffbf, 1'b1);
        tick();
        check("latency_push_edge", {15'b0, tx}, 16'h0001);
        drive(STAT, 16'h0000, 1'b0);
        tick();
        check("latency_pop_edge", {15'b0, tx}, 16'h0000);
        busy_cycles = 1;
        for (int k = 1; k < 100; k++) begin
            tick();
            if (!tx_busy) break;
            check($sformatf("frame41_k%0d", k), {15'b0, tx}, {15'b0, frame_41[k / C]});
            busy_cycles++;
        end
        check("busy_cycles", 16'(busy_cycles), 16'd40);

        // 3. five consecutive stores while idle: bytes 01..05
        for (int i = 1; i <= 5; i++) begin
            drive(BASE, 16'(0 - i), 1'b1);
            tick();
        end
        drive(STAT, 16'h0000, 1'b0);
        #1;
        check("five_no_overflow", {15'b0, bus_rdata[3]}, 16'h0000);
        for (int i = 0; i < 5 * (10 * C + 1) + 5; i++) tick();
        check("five_drained", bus_rdata, 16'h0002);

        // 4. six back-to-back stores while a frame is active
        drive(BASE, 16'hffaa, 1'b1);
        tick();
        drive(STAT, 16'h0000, 1'b0);
        tick();
        for (int i = 0; i < 6; i++) begin
            drive(BASE, 16'(16'hffc0 - i), 1'b1);
            tick();
        end
        drive(STAT, 16'h0000, 1'b0);
        tick();
        check("ovf_full_busy", bus_rdata, 16'h000d);
        wait_busy(1'b0, 100);
        check("ovf_full_idle", bus_rdata, 16'h0009);
        tick();
        check("ovf_after_pop", bus_rdata, 16'h000c);
        drive(STAT, 16'h0000, 1'b1);
        tick();
        drive(STAT, 16'h0000, 1'b0);
        #1;
        check("ovf_cleared", bus_rdata, 16'h0004);
        for (int i = 0; i < 4 * (10 * C + 1) + 5; i++) tick();
        check("ovf_drained", bus_rdata, 16'h0002);

        // 5. reset during DATA bit 3, with a second byte queued
        drive(BASE, 16'hff55, 1'b1);
        tick();
        drive(STAT, 16'h0000, 1'b0);
        tick();
        drive(BASE, 16'hfff0, 1'b1);
        tick();
        drive(STAT, 16'h0000, 1'b0);
        for (int i = 0; i < 4 * C - 1; i++) tick();
        areset = 1'b1;
        tick();
        areset = 1'b0;
        check("rst_tx", {15'b0, tx}, 16'h0001);
        check("rst_status", bus_rdata, 16'h0002);
        for (int i = 0; i < 10; i++) tick();
        check("rst_discarded", {15'b0, tx_busy}, 16'h0000);
        drive(BASE, 16'hffbf, 1'b1);
        tick();
        drive(STAT, 16'h0000, 1'b0);
        wait_busy(1'b1, 10);
        wait_busy(1'b0, 100);

        // 6. store and read outside the window
        drive(16'hff02, 16'hff00, 1'b1);
        tick();
        drive(16'hff02, 16'h0000, 1'b0);
        #1;
        check("out_sel", {15'b0, bus_sel}, 16'h0000);
        check("out_rdata", bus_rdata, 16'h0000);
        for (int i = 0; i < 4; i++) tick();
        drive(STAT, 16'h0000, 1'b0);
        #1;
        check("out_status", bus_rdata, 16'h0002);
        check("out_tx", {15'b0, tx}, 16'h0001);

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            r = int'($urandom_range(0, 199));
            areset = 1'b0;
            if (r < 12)       drive(BASE, 16'($urandom), 1'b1);
            else if (r < 16)  drive(STAT, 16'($urandom), 1'b1);
            else if (r < 22)  drive(16'($urandom), 16'($urandom), 1'b1);
            else if (r < 24)  begin areset = 1'b1; drive(STAT, 16'h0000, 1'b0); end
            else if (r < 120) drive(STAT, 16'h0000, 1'b0);
            else if (r < 150) drive(BASE, 16'h0000, 1'b0);
            else              drive(16'($urandom), 16'h0000, 1'b0);
            tick();
        end
        areset = 1'b0;
        drive(STAT, 16'h0000, 1'b0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
